// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode seven-segment driver with per-frame input snapshot.
// Optional hex glyphs for nibbles 10-15 when SEVSEG_HEX_EN is defined.
module seven_seg_scanner #(
    parameter int NUM_DIGITS       = 4,
    parameter int CLK_DIV          = 50000,
    parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    blank_lz,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int P_W   = $clog2(CLK_DIV);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [P_W-1:0]        P_LAST   = P_W'(CLK_DIV - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{ANODE_ACTIVE_LOW}};

    logic [P_W-1:0]          p_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic [4*NUM_DIGITS-1:0] snap_d_reg;
    logic [NUM_DIGITS-1:0]   snap_dp_reg;
    logic                    en_d_reg;
    logic [7:0]              seg_reg, seg_next;
    logic [NUM_DIGITS-1:0]   an_reg, an_next;
    logic                    frame_done_reg;

    logic tick, wrap, start;
    logic [7:0] digit_seg [NUM_DIGITS];

    function automatic logic [6:0] decode7(input logic [3:0] n);
        case (n)
            4'h0:    decode7 = 7'b1000000;
            4'h1:    decode7 = 7'b1111001;
            4'h2:    decode7 = 7'b0100100;
            4'h3:    decode7 = 7'b0110000;
            4'h4:    decode7 = 7'b0011001;
            4'h5:    decode7 = 7'b0010010;
            4'h6:    decode7 = 7'b0000010;
            4'h7:    decode7 = 7'b1111000;
            4'h8:    decode7 = 7'b0000000;
            4'h9:    decode7 = 7'b0010000;
`ifdef SEVSEG_HEX_EN
            4'hA:    decode7 = 7'b0001000;
            4'hB:    decode7 = 7'b0000011;
            4'hC:    decode7 = 7'b1000110;
            4'hD:    decode7 = 7'b0100001;
            4'hE:    decode7 = 7'b0000110;
            4'hF:    decode7 = 7'b0001110;
`endif
            default: decode7 = 7'b1000000;
        endcase
    endfunction

    // The first enabled cycle starts a fresh frame: counters held at 0 and inputs reloaded,
    // so digit 0 gets a full CLK_DIV slot once the output stage catches up.
    assign start = enable && !en_d_reg;
    assign tick  = enable && (p_reg == P_LAST);
    assign wrap  = tick && (idx_reg == IDX_LAST);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic blank;
            if (gi == 0) begin : g_lsd
                assign blank = 1'b0;
            end else begin : g_upper
                // Blank only when this digit and everything to its left is zero
                assign blank = blank_lz && (snap_d_reg[4*NUM_DIGITS-1:4*gi] == '0);
            end
            assign digit_seg[gi] = {~snap_dp_reg[gi],
                                    blank ? 7'h7F : decode7(snap_d_reg[4*gi +: 4])};
        end
    endgenerate

    always_comb begin
        seg_next = 8'hFF;
        an_next  = AN_OFF;
        if (en_d_reg) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (idx_reg == IDX_W'(k)) begin
                    seg_next   = digit_seg[k];
                    an_next[k] = ~ANODE_ACTIVE_LOW;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_reg          <= '0;
            idx_reg        <= '0;
            snap_d_reg     <= '0;
            snap_dp_reg    <= '0;
            en_d_reg       <= 1'b0;
            seg_reg        <= 8'hFF;
            an_reg         <= AN_OFF;
            frame_done_reg <= 1'b0;
        end else begin
            en_d_reg       <= enable;
            seg_reg        <= seg_next;
            an_reg         <= an_next;
            frame_done_reg <= wrap;

            if (!enable || start) begin
                p_reg   <= '0;
                idx_reg <= '0;
            end else if (tick) begin
                p_reg   <= '0;
                idx_reg <= wrap ? '0 : idx_reg + IDX_W'(1);
            end else begin
                p_reg   <= p_reg + P_W'(1);
            end

            if (!enable || start || wrap) begin
                snap_d_reg  <= digits;
                snap_dp_reg <= dp;
            end
        end
    end

    assign seg        = seg_reg;
    assign an         = an_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: 4-digit and 1-digit instances checked against a
// frame-position model every cycle, plus hand-computed waveform points.
module tb_seven_seg_scanner;

    localparam int N  = 4;
    localparam int CD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        blank_lz = 1'b0;
    logic [15:0] digits = 16'h1234;
    logic [3:0]  dp = 4'b0000;

    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_done;
    logic [7:0]  seg1;
    logic [0:0]  an1;
    logic        frame_done1;

    int checks = 0;
    int failures = 0;
    int e = 0;

    seven_seg_scanner #(.NUM_DIGITS(N), .CLK_DIV(CD), .ANODE_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .digits(digits), .dp(dp),
        .blank_lz(blank_lz), .seg(seg), .an(an), .frame_done(frame_done)
    );

    seven_seg_scanner #(.NUM_DIGITS(1), .CLK_DIV(CD), .ANODE_ACTIVE_LOW(1'b1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .digits(digits[3:0]), .dp(dp[0:0]),
        .blank_lz(blank_lz), .seg(seg1), .an(an1), .frame_done(frame_done1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, e, act, exp);
        end
    endtask

    function automatic logic [6:0] dec(input logic [3:0] n);
        logic [6:0] tbl [16];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
`ifdef SEVSEG_HEX_EN
        tbl[10] = 7'h08; tbl[11] = 7'h03; tbl[12] = 7'h46;
        tbl[13] = 7'h21; tbl[14] = 7'h06; tbl[15] = 7'h0E;
`endif
        return tbl[n];
    endfunction

    function automatic logic [7:0] code(input logic [15:0] s, input logic [3:0] sp,
                                        input int pos, input logic lz);
        logic [6:0] g;
        g = dec(s[4*pos +: 4]);
        if (pos > 0 && lz && ((s >> (4*pos)) == 16'h0)) g = 7'h7F;
        return {~sp[pos], g};
    endfunction

    // Model: k counts cycles since the frame-start edge; the lit digit and frame
    // wraps follow from k by division, the snapshot from the capture rules.
    int          k = 0;
    bit          en_prev = 1'b0;
    logic [15:0] sd = '0;
    logic [3:0]  sdp = '0;
    logic [3:0]  sd1 = '0;
    logic        sdp1 = 1'b0;

    initial begin
        forever begin
            int kn, pos;
            logic [7:0] es, es1;
            logic [3:0] ea;
            logic ea1, ef, ef1;
            @(posedge clk);
            #1;
            if (rst) begin
                k = 0; en_prev = 1'b0; sd = '0; sdp = '0; sd1 = '0; sdp1 = 1'b0;
            end else begin
                es = 8'hFF; ea = 4'hF; es1 = 8'hFF; ea1 = 1'b1;
                if (en_prev) begin
                    pos = (k / CD) % N;
                    es = code(sd, sdp, pos, blank_lz);
                    ea[pos] = 1'b0;
                    es1 = {~sdp1, dec(sd1)};
                    ea1 = 1'b0;
                end
                kn  = (enable && en_prev) ? k + 1 : 0;
                ef  = enable && en_prev && (kn % (N*CD) == 0);
                ef1 = enable && en_prev && (kn % CD == 0);
                chk("model_seg", seg, es);
                chk("model_an", an, ea);
                chk("model_frame_done", frame_done, ef);
                chk("model_seg1", seg1, es1);
                chk("model_an1", an1, ea1);
                chk("model_frame_done1", frame_done1, ef1);
                if (!enable || !en_prev || ef) begin sd = digits; sdp = dp; end
                if (!enable || !en_prev || ef1) begin sd1 = digits[3:0]; sdp1 = dp[0]; end
                k = kn;
                en_prev = enable;
            end
        end
    end

    task automatic adv();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic wait_to(input int t);
        while (e < t) adv();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seg_tbl [4];
        logic [3:0] an_tbl [4];
        seg_tbl = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        an_tbl  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        repeat (3) adv();
        #1; rst = 1'b0; enable = 1'b1;
        e = 0;

        // Reset asserted in the middle of digit 1
        wait_to(7);
        chk("pre_reset_seg", seg, 8'hB0);
        #1; rst = 1'b1;
        #1;
        chk("async_reset_seg", seg, 8'hFF);
        chk("async_reset_an", an, 4'hF);
        chk("async_reset_frame_done", frame_done, 1'b0);
        adv(); adv();
        #1; rst = 1'b0;
        e = 0;

        // Basic scan of 1234
        for (int i = 0; i < 16; i++) begin
            wait_to(2 + i);
            chk("scan_seg", seg, seg_tbl[i/4]);
            chk("scan_an", an, an_tbl[i/4]);
            chk("scan_frame_done", frame_done, (i == 15) ? 1'b1 : 1'b0);
        end

        // Mid-frame update stays hidden until the next frame
        wait_to(20);
        #1; digits = 16'h5678;
        wait_to(33);
        chk("tear_old_seg", seg, 8'hF9);
        chk("tear_frame_done", frame_done, 1'b1);
        wait_to(34);
        chk("tear_new_seg", seg, 8'h80);
        chk("tear_new_an", an, 4'b1110);

        // Leading-zero blanking
        #1; digits = 16'h0070; dp = 4'b1000; blank_lz = 1'b1;
        wait_to(50); chk("lz_d0", seg, 8'hC0);
        wait_to(54); chk("lz_d1", seg, 8'hF8);
        wait_to(58); chk("lz_d2", seg, 8'hFF);
        chk("lz_d2_an", an, 4'b1011);
        wait_to(62); chk("lz_d3", seg, 8'h7F);
        #1; blank_lz = 1'b0;
        wait_to(63); chk("nolz_d3", seg, 8'h40);
        wait_to(74); chk("nolz_d2", seg, 8'hC0);

        // Enable gating during digit 2
        #1; enable = 1'b0; digits = 16'h0009;
        wait_to(75); chk("dis_first_seg", seg, 8'hC0);
        wait_to(76);
        chk("dis_seg", seg, 8'hFF);
        chk("dis_an", an, 4'hF);
        chk("dis_frame_done", frame_done, 1'b0);
        wait_to(79);
        #1; enable = 1'b1;
        wait_to(81);
        chk("reen_seg", seg, 8'h90);
        chk("reen_an", an, 4'b1110);
        chk("reen_an1", an1, 1'b0);
        wait_to(83); chk("n1_no_pulse", frame_done1, 1'b0);
        wait_to(84);
        chk("reen_hold_seg", seg, 8'h90);
        chk("n1_pulse", frame_done1, 1'b1);
        wait_to(85);
        chk("reen_d1_seg", seg, 8'hC0);
        chk("reen_d1_an", an, 4'b1101);

        // Hex decode
        wait_to(86);
        #1; digits = 16'hABCF; dp = 4'b0000;
`ifdef SEVSEG_HEX_EN
        wait_to(97);  chk("hex_d0", seg, 8'h8E);
        wait_to(101); chk("hex_d1", seg, 8'hC6);
        wait_to(105); chk("hex_d2", seg, 8'h83);
        wait_to(109); chk("hex_d3", seg, 8'h88);
`else
        wait_to(97);  chk("hex_d0", seg, 8'hC0);
        wait_to(101); chk("hex_d1", seg, 8'hC0);
        wait_to(105); chk("hex_d2", seg, 8'hC0);
        wait_to(109); chk("hex_d3", seg, 8'hC0);
`endif
        wait_to(112);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
